// File: rtl/dds_pkg.sv
// Shared constants and FSM encoding for the DDS frequency meter and the ip_dds wrapper.
package dds_pkg;

  localparam int DDS_PHASE_W   = 16;
  localparam int DDS_NCYC_LOG2 = 4;
  localparam int NCYC          = 1 << DDS_NCYC_LOG2;
  localparam int DIV_CYCLES    = DDS_NCYC_LOG2 + DDS_PHASE_W + 1;
  localparam logic [DIV_CYCLES-1:0] DIVIDEND = {1'b1, {(DIV_CYCLES-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DIV,
    S_DONE
  } meter_state_e;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Sample input and frequency result bundle of the DDS frequency meter.
interface dds_freq_meter_if #(
  parameter int SAMPLE_W = 10,
  parameter int PHASE_W  = 16
);
  logic                       i_en;
  logic                       i_sample_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic [PHASE_W-1:0]         o_freq_word;
  logic                       o_freq_valid;
  logic                       o_timeout;
  logic                       o_busy;

  modport master (
    output i_en, i_sample_valid, i_sample,
    input  o_freq_word, o_freq_valid, o_timeout, o_busy
  );

  modport slave (
    input  i_en, i_sample_valid, i_sample,
    output o_freq_word, o_freq_valid, o_timeout, o_busy
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: fixed dividend, one dividend bit per clock, quotient saturated to Q_W bits.
module seq_divider #(
  parameter int             N_W      = 21,
  parameter logic [N_W-1:0] DIVIDEND = {1'b1, {(N_W-1){1'b0}}},
  parameter int             D_W      = 24,
  parameter int             Q_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [D_W-1:0] i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [Q_W-1:0] o_quot
);

  localparam int CW = $clog2(N_W + 1);

  logic [CW-1:0]  r_cnt;
  logic [D_W-1:0] r_div;
  logic [D_W-1:0] r_rem;
  logic [N_W-1:0] r_q;
  logic           r_done;
  logic [CW-1:0]  w_idx;
  logic [D_W:0]   w_trial;
  logic [D_W:0]   w_diff;
  logic           w_ge;

  // r_cnt counts the remaining dividend bits; w_idx selects the bit shifted in now
  assign w_idx   = r_cnt - {{(CW-1){1'b0}}, 1'b1};
  assign w_trial = {r_rem, DIVIDEND[w_idx]};
  assign w_diff  = w_trial - {1'b0, r_div};
  assign w_ge    = (w_trial >= {1'b0, r_div});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_cnt <= CW'(N_W);
        r_div <= i_divisor;
        r_rem <= '0;
        r_q   <= '0;
      end else if (r_cnt != '0) begin
        r_rem  <= w_ge ? w_diff[D_W-1:0] : w_trial[D_W-1:0];
        r_q    <= {r_q[N_W-2:0], w_ge};
        r_cnt  <= w_idx;
        r_done <= (w_idx == '0);
      end
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = r_done;
  assign o_quot = (|r_q[N_W-1:Q_W]) ? {Q_W{1'b1}} : r_q[Q_W-1:0];

endmodule

// File: rtl/dds_freq_meter.sv
// Measures a sampled sinusoid over 2^NCYC_LOG2 rising crossings and reports a DDS phase increment.
//   state | meaning
//   IDLE  | disabled, outputs hold
//   ARM   | waiting for the first rising crossing
//   COUNT | counting samples and crossings
//   DIV   | dividing 2^(NCYC_LOG2+PHASE_W) by the sample count
//   DONE  | one-cycle result publish
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int SAMPLE_W  = 10,
  parameter int PHASE_W   = DDS_PHASE_W,
  parameter int NCYC_LOG2 = DDS_NCYC_LOG2,
  parameter int CNT_W     = 24,
  parameter int HYST      = 8
) (
  input logic             clk,
  input logic             rst_n,
  dds_freq_meter_if.slave bus
);

  localparam int PER_W = NCYC_LOG2 + 1;
  localparam int DIV_N = NCYC_LOG2 + PHASE_W + 1;
  localparam logic [DIV_N-1:0] DIV_DIVIDEND = {1'b1, {(DIV_N-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] TH_HI = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] TH_LO = SAMPLE_W'(-HYST);

  meter_state_e       r_state, w_state_nx;
  logic               r_armed, w_armed_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
  logic [PER_W-1:0]   r_per, w_per_nx, w_per_inc;
  logic [PHASE_W-1:0] r_freq_word, w_freq_word_nx;
  logic               r_freq_valid, w_freq_valid_nx;
  logic               r_timeout, w_timeout_nx;
  logic               w_arm_lvl, w_cross;
  logic               w_div_start, w_div_busy, w_div_done;
  logic [PHASE_W-1:0] w_quot;

  assign w_arm_lvl = (bus.i_sample < TH_LO);
  assign w_cross   = bus.i_sample_valid && r_armed && (bus.i_sample >= TH_HI);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_per_inc = r_per + PER_W'(1);

  always_comb begin
    w_state_nx      = r_state;
    w_armed_nx      = r_armed;
    w_cnt_nx        = r_cnt;
    w_per_nx        = r_per;
    w_freq_word_nx  = r_freq_word;
    w_freq_valid_nx = 1'b0;
    w_timeout_nx    = r_timeout;
    w_div_start     = 1'b0;

    // detector is frozen outside ARM/COUNT
    if ((r_state == S_ARM || r_state == S_COUNT) && bus.i_sample_valid) begin
      if (w_arm_lvl)    w_armed_nx = 1'b1;
      else if (w_cross) w_armed_nx = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_state_nx = S_ARM;
        w_armed_nx = 1'b0;
      end
      S_ARM: begin
        if (w_cross) begin
          w_state_nx = S_COUNT;
          w_cnt_nx   = '0;
          w_per_nx   = '0;
        end
      end
      S_COUNT: begin
        if (bus.i_sample_valid) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cross) w_per_nx = w_per_inc;
          if (w_cross && (w_per_inc == PER_W'(1 << NCYC_LOG2))) begin
            w_div_start = 1'b1;
            w_state_nx  = S_DIV;
          end else if (w_cnt_inc == {CNT_W{1'b1}}) begin
            w_state_nx      = S_DONE;
            w_freq_word_nx  = '0;
            w_freq_valid_nx = 1'b1;
            w_timeout_nx    = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (w_div_done && !w_div_busy) begin
          w_state_nx      = S_DONE;
          w_freq_word_nx  = w_quot;
          w_freq_valid_nx = 1'b1;
          w_timeout_nx    = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nx = S_ARM;
        w_armed_nx = 1'b0;
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (!bus.i_en) begin
      w_state_nx      = S_IDLE;
      w_freq_word_nx  = r_freq_word;
      w_freq_valid_nx = 1'b0;
      w_timeout_nx    = r_timeout;
      w_div_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_per        <= '0;
      r_freq_word  <= '0;
      r_freq_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_armed      <= w_armed_nx;
      r_cnt        <= w_cnt_nx;
      r_per        <= w_per_nx;
      r_freq_word  <= w_freq_word_nx;
      r_freq_valid <= w_freq_valid_nx;
      r_timeout    <= w_timeout_nx;
    end
  end

  seq_divider #(
    .N_W      (DIV_N),
    .DIVIDEND (DIV_DIVIDEND),
    .D_W      (CNT_W),
    .Q_W      (PHASE_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_div_start),
    .i_divisor (w_cnt_inc),
    .o_busy    (w_div_busy),
    .o_done    (w_div_done),
    .o_quot    (w_quot)
  );

  assign bus.o_freq_word  = r_freq_word;
  assign bus.o_freq_valid = r_freq_valid;
  assign bus.o_timeout    = r_timeout;
  assign bus.o_busy       = (r_state != S_IDLE);

endmodule
